// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch PC sequencer with I-cache miss/refill handling.
// Tracks the fetch PC through redirects, predictions and stalls, issues line
// refill requests on I-cache misses and counts misses.
// Optional build macro: FETCH_MISS_TIMEOUT_EN adds a refill timeout that
// abandons a refill after MISS_TIMEOUT cycles and raises an instruction fault.
module fetch_ctrl #(
    parameter logic [31:0] BOOT_PC      = 32'h0000_1000,
    parameter int          MISS_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_core_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        pred_taken_i,
    input  logic [31:0] pred_pc_i,
    input  logic        icache_hit_i,
    input  logic        mem_ack_i,
    output logic [31:0] fetch_pc_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        icache_fill_o,
    output logic        stall_fetch_o,
    output logic        kill_o,
    output logic        fetch_misaligned_instr_exc_o,
    output logic        fetch_instr_fault_exc_o,
    output logic [15:0] miss_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2,
        FILL = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic        pc_aligned;
    logic        run_miss;
    logic [31:0] resume_pc;
    logic        timeout;

    assign pc_aligned = (pc_q[1:0] == 2'b00);
    assign run_miss   = !icache_hit_i && !redirect_i && pc_aligned;

    // PC to resume at after a refill ends: a redirect arriving this very cycle
    // is the latest and wins over an older pended target.
    assign resume_pc = redirect_i ? redirect_pc_i :
                       pend_v_q   ? pend_pc_q     : pc_q;

`ifdef FETCH_MISS_TIMEOUT_EN
    logic [7:0] tmo_q;

    // Count cycles spent in MISS; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != MISS) begin
            tmo_q <= 8'd0;
        end else begin
            tmo_q <= tmo_q + 8'd1;
        end
    end

    // Fires on the MISS_TIMEOUT-th waiting cycle; a coincident ack still wins.
    assign timeout                 = (state_q == MISS) && !mem_ack_i &&
                                     (tmo_q == 8'(MISS_TIMEOUT - 1));
    assign fetch_instr_fault_exc_o = timeout;
`else
    assign timeout                 = 1'b0;
    assign fetch_instr_fault_exc_o = (MISS_TIMEOUT < 0);
`endif

    // Next-state, next-PC and per-state outputs.
    always_comb begin
        state_d                      = state_q;
        pc_d                         = pc_q;
        pend_v_d                     = pend_v_q;
        pend_pc_d                    = pend_pc_q;
        miss_cnt_d                   = miss_cnt_q;
        mem_req_o                    = 1'b0;
        icache_fill_o                = 1'b0;
        stall_fetch_o                = 1'b0;
        fetch_misaligned_instr_exc_o = 1'b0;

        case (state_q)
            IDLE: begin
                stall_fetch_o = 1'b1;
                state_d       = RUN;
            end
            RUN: begin
                fetch_misaligned_instr_exc_o = !pc_aligned;
                if (run_miss) begin
                    mem_req_o     = 1'b1;
                    stall_fetch_o = 1'b1;
                    state_d       = MISS;
                    if (miss_cnt_q != 16'hFFFF) begin
                        miss_cnt_d = miss_cnt_q + 16'd1;
                    end
                end
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end else if (stall_core_i || run_miss) begin
                    pc_d = pc_q;
                end else if (pred_taken_i) begin
                    pc_d = pred_pc_i;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            MISS: begin
                mem_req_o     = 1'b1;
                stall_fetch_o = 1'b1;
                if (redirect_i) begin
                    pend_v_d  = 1'b1;
                    pend_pc_d = redirect_pc_i;
                end
                if (mem_ack_i) begin
                    state_d = FILL;
                end else if (timeout) begin
                    state_d  = RUN;
                    pc_d     = resume_pc;
                    pend_v_d = 1'b0;
                end
            end
            FILL: begin
                icache_fill_o = 1'b1;
                stall_fetch_o = 1'b1;
                state_d       = RUN;
                pc_d          = resume_pc;
                pend_v_d      = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset taking priority over all inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pc_q       <= BOOT_PC;
            pend_v_q   <= 1'b0;
            pend_pc_q  <= 32'd0;
            miss_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_v_q   <= pend_v_d;
            pend_pc_q  <= pend_pc_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign fetch_pc_o   = pc_q;
    assign miss_count_o = miss_cnt_q;
    assign kill_o       = redirect_i && (state_q != IDLE);
    assign mem_addr_o   = mem_req_o ? {pc_q[31:4], 4'b0000} : 32'd0;

endmodule
